mofsm_seq_gen: RTL and testbench

Serial pattern transmitter that drives the single-bit stream consumed by the `mofsm` Moore sequence detector. On a start request it captures a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock. It can optionally append a parity bit, then holds the line low for a programmable gap and reports completion. It sits on the stimulus/producer side of the detector's `a` input and is used both in the bench and as an on-chip pattern source.

---
 rtl/mofsm_pkg.sv | 17 +
 rtl/mofsm_down_cnt.sv | 31 +++
 rtl/mofsm_seq_gen.sv | 157 +++++++++++++++
 tb/tb_mofsm_seq_gen.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mofsm_pkg.sv
// Shared types and constants for the mofsm detector and its serial pattern source.
// Used by mofsm_seq_gen (optional parity via MOFSM_SEQ_GEN_PARITY_EN).
package mofsm_pkg;

   // Fixed encodings so waveforms and benches decode states consistently.
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StSend = 3'd1,
      StPar  = 3'd2,
      StGap  = 3'd3,
      StDone = 3'd4
   } seq_gen_state_t;

   // Target sequence recognised by the mofsm detector.
   localparam logic [3:0] MOFSM_PAT = 4'b1011;

endpackage

// File: rtl/mofsm_down_cnt.sv
// Loadable down-counter that saturates at zero and flags the zero count.
module mofsm_down_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   always_comb begin
      o_count = r_count;
      o_zero  = (r_count == '0);
   end

endmodule

// File: rtl/mofsm_seq_gen.sv
// Serial MSB-first pattern transmitter feeding the mofsm detector input.
// Define MOFSM_SEQ_GEN_PARITY_EN to append an even-parity bit after the data bits.
module mofsm_seq_gen
   import mofsm_pkg::*;
#(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned GAP_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic [GAP_W-1:0] i_gap,
   output logic             o_a_out,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned BIT_W = $clog2(PAT_W + 1);

   seq_gen_state_t   r_state;
   seq_gen_state_t   w_state_next;
   logic [PAT_W-1:0] r_shift;
   logic             w_accept;
   logic             w_bit_dec;
   logic [BIT_W-1:0] w_bit_cnt;
   logic             w_bit_zero;
   logic             w_bit_last;
   logic             w_gap_dec;
   logic [GAP_W-1:0] w_gap_cnt;
   logic             w_gap_zero;
   logic             w_gap_last;
`ifdef MOFSM_SEQ_GEN_PARITY_EN
   logic             r_par;
`endif

   // A new frame is only taken when not busy: from IDLE or back-to-back from DONE.
   always_comb begin
      w_accept   = i_start && ((r_state == StIdle) || (r_state == StDone));
      w_bit_dec  = (r_state == StSend) && !w_bit_zero;
      w_bit_last = (w_bit_cnt == BIT_W'(1));
      w_gap_dec  = (r_state == StGap);
      w_gap_last = (w_gap_cnt == GAP_W'(1));
   end

   mofsm_down_cnt #(
      .W (BIT_W)
   ) u_bit_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_accept),
      .i_load_val (BIT_W'(PAT_W)),
      .i_dec      (w_bit_dec),
      .o_count    (w_bit_cnt),
      .o_zero     (w_bit_zero)
   );

   mofsm_down_cnt #(
      .W (GAP_W)
   ) u_gap_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_accept),
      .i_load_val (i_gap),
      .i_dec      (w_gap_dec),
      .o_count    (w_gap_cnt),
      .o_zero     (w_gap_zero)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (i_start) w_state_next = StSend;
         end
         StSend: begin
            if (w_bit_last) begin
`ifdef MOFSM_SEQ_GEN_PARITY_EN
               w_state_next = StPar;
`else
               w_state_next = w_gap_zero ? StDone : StGap;
`endif
            end
         end
`ifdef MOFSM_SEQ_GEN_PARITY_EN
         StPar: begin
            w_state_next = w_gap_zero ? StDone : StGap;
         end
`endif
         StGap: begin
            if (w_gap_last) w_state_next = StDone;
         end
         StDone: begin
            w_state_next = i_start ? StSend : StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shift <= '0;
      end else if (w_accept) begin
         r_shift <= i_pattern;
      end else if (r_state == StSend) begin
         r_shift <= {r_shift[PAT_W-2:0], 1'b0};
      end
   end

`ifdef MOFSM_SEQ_GEN_PARITY_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_par <= 1'b0;
      end else if (w_accept) begin
         r_par <= ^i_pattern;
      end
   end
`endif

   always_comb begin
      o_a_out = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (r_state)
         StSend: begin
            o_a_out = r_shift[PAT_W-1];
            o_busy  = 1'b1;
         end
`ifdef MOFSM_SEQ_GEN_PARITY_EN
         StPar: begin
            o_a_out = r_par;
            o_busy  = 1'b1;
         end
`endif
         StGap: begin
            o_busy = 1'b1;
         end
         StDone: begin
            o_done = 1'b1;
         end
         default: begin
            o_a_out = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mofsm_seq_gen.sv
// Self-checking bench for mofsm_seq_gen against a frame-level queue model.
// Honours MOFSM_SEQ_GEN_PARITY_EN to expect the appended parity bit.
module tb_mofsm_seq_gen;
   import mofsm_pkg::*;

   localparam int unsigned PAT_W = 4;
   localparam int unsigned GAP_W = 4;
`ifdef MOFSM_SEQ_GEN_PARITY_EN
   localparam int unsigned PAR_BITS = 1;
`else
   localparam int unsigned PAR_BITS = 0;
`endif

   typedef struct packed {
      logic a;
      logic busy;
      logic done;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [GAP_W-1:0] gap;
   logic             a_out;
   logic             busy;
   logic             done;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done   = 0;
   exp_t q[$];
   exp_t cur = '0;

   mofsm_seq_gen #(
      .PAT_W (PAT_W),
      .GAP_W (GAP_W)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_pattern (pattern),
      .i_gap     (gap),
      .o_a_out   (a_out),
      .o_busy    (busy),
      .o_done    (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Whole frame as seen on the outputs: data bits, optional parity, gap lows, done.
   task automatic build_frame(input logic [PAT_W-1:0] pat, input logic [GAP_W-1:0] g);
      q.delete();
      for (int k = 0; k < int'(PAT_W); k++) q.push_back('{a: pat[PAT_W-1-k], busy: 1'b1, done: 1'b0});
      if (PAR_BITS == 1) q.push_back('{a: ^pat, busy: 1'b1, done: 1'b0});
      for (int k = 0; k < int'(g); k++) q.push_back('{a: 1'b0, busy: 1'b1, done: 1'b0});
      q.push_back('{a: 1'b0, busy: 1'b0, done: 1'b1});
   endtask

   task automatic step(input logic st, input logic [PAT_W-1:0] pat, input logic [GAP_W-1:0] g,
                       input logic r);
      start   = st;
      pattern = pat;
      gap     = g;
      rst     = r;
      @(posedge clk);
      if (r) begin
         q.delete();
         cur = '0;
      end else begin
         if (!cur.busy && st) build_frame(pat, g);
         cur = (q.size() != 0) ? q.pop_front() : exp_t'('0);
      end
      #1;
      check_eq("a_out", {31'd0, a_out}, {31'd0, cur.a});
      check_eq("busy", {31'd0, busy}, {31'd0, cur.busy});
      check_eq("done", {31'd0, done}, {31'd0, cur.done});
      check_eq("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) n_done++;
   endtask

   initial begin
      int done_before;
      rst     = 1'b1;
      start   = 1'b0;
      pattern = '0;
      gap     = '0;

      for (int i = 0; i < 5; i++) step(1'b0, 4'hF, 4'hF, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 4'hF, 4'h3, 1'b0);

      // Detector target with no gap, then idle.
      step(1'b1, MOFSM_PAT, 4'd0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 4'h0, 1'b0);

      // Back-to-back frames with start held high.
      for (int i = 0; i < 24; i++) step(1'b1, 4'b0110, 4'd3, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 4'h0, 1'b0);

      // Start pulse during a busy frame must be ignored.
      done_before = n_done;
      step(1'b1, 4'b1001, 4'd2, 1'b0);
      step(1'b0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 4'b0111, 4'd5, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 4'h0, 1'b0);
      check_eq("single_done", n_done - done_before, 32'd1);

      // Reset mid-frame, then a clean frame with the maximum gap.
      step(1'b1, 4'b1111, 4'd2, 1'b0);
      step(1'b0, 4'h0, 4'h0, 1'b0);
      step(1'b0, 4'h0, 4'h0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 4'b1101, 4'hF, 1'b0);
      for (int i = 0; i < 24; i++) step(1'b0, 4'h0, 4'h0, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 2) == 0), PAT_W'($urandom), GAP_W'($urandom),
              ($urandom_range(0, 79) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
